// File: rtl/axi_pkg.sv
// Shared AXI definitions for the default slave: response codes, FSM state
// encodings and the default bus widths of the crossbar's default-slave port.
package axi_pkg;

  localparam int AXI_ID_W   = 8;
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_LEN_W  = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

endpackage

// File: rtl/axi_default_slave.sv
// AXI4 default slave: answers every unmapped write with DECERR and every read
// with ARLEN+1 zero DECERR beats. Optional error logging under DEFAULT_SLAVE_LOG_EN.
//
// state  | meaning
// W_IDLE | waiting for AW, AWREADY high
// W_DATA | draining W beats until WLAST
// W_RESP | holding B (DECERR) until BREADY
// R_IDLE | waiting for AR, ARREADY high
// R_DATA | returning zero beats, RLAST when cnt == len
module axi_default_slave
  import axi_pkg::*;
#(
  parameter int ID_W   = AXI_ID_W,
  parameter int ADDR_W = AXI_ADDR_W,
  parameter int DATA_W = AXI_DATA_W,
  parameter int LEN_W  = AXI_LEN_W
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [ID_W-1:0]   AWID,
  input  logic [ADDR_W-1:0] AWADDR,
  input  logic [LEN_W-1:0]  AWLEN,
  input  logic              AWVALID,
  output logic              AWREADY,
  input  logic              WLAST,
  input  logic              WVALID,
  output logic              WREADY,
  output logic [ID_W-1:0]   BID,
  output logic [1:0]        BRESP,
  output logic              BVALID,
  input  logic              BREADY,
  input  logic [ID_W-1:0]   ARID,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic [LEN_W-1:0]  ARLEN,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [ID_W-1:0]   RID,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  output logic              RVALID,
  input  logic              RREADY
`ifdef DEFAULT_SLAVE_LOG_EN
  ,
  output logic [ADDR_W-1:0] err_addr,
  output logic [15:0]       err_cnt
`endif
);

  w_state_t          w_state_q, w_state_d;
  logic [ID_W-1:0]   bid_q, bid_d;

  r_state_t          r_state_q, r_state_d;
  logic [ID_W-1:0]   rid_q, rid_d;
  logic [LEN_W-1:0]  rlen_q, rlen_d;
  logic [LEN_W-1:0]  rcnt_q, rcnt_d;

  logic              aw_hs;
  logic              ar_hs;

  assign aw_hs = AWVALID && (w_state_q == W_IDLE);
  assign ar_hs = ARVALID && (r_state_q == R_IDLE);

  // Write FSM
  always_comb begin
    w_state_d = w_state_q;
    bid_d     = bid_q;
    case (w_state_q)
      W_IDLE: begin
        if (AWVALID) begin
          bid_d     = AWID;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (WVALID && WLAST) w_state_d = W_RESP;
      end
      W_RESP: begin
        if (BREADY) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state_q <= W_IDLE;
      bid_q     <= '0;
    end else begin
      w_state_q <= w_state_d;
      bid_q     <= bid_d;
    end
  end

  assign AWREADY = (w_state_q == W_IDLE);
  assign WREADY  = (w_state_q == W_DATA);
  assign BVALID  = (w_state_q == W_RESP);
  assign BID     = bid_q;
  assign BRESP   = RESP_DECERR;

  // Read FSM; the counter stops at len, so ARLEN=all-ones never wraps
  always_comb begin
    r_state_d = r_state_q;
    rid_d     = rid_q;
    rlen_d    = rlen_q;
    rcnt_d    = rcnt_q;
    case (r_state_q)
      R_IDLE: begin
        if (ARVALID) begin
          rid_d     = ARID;
          rlen_d    = ARLEN;
          rcnt_d    = '0;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (RREADY) begin
          if (rcnt_q == rlen_q) r_state_d = R_IDLE;
          else                  rcnt_d    = rcnt_q + LEN_W'(1);
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state_q <= R_IDLE;
      rid_q     <= '0;
      rlen_q    <= '0;
      rcnt_q    <= '0;
    end else begin
      r_state_q <= r_state_d;
      rid_q     <= rid_d;
      rlen_q    <= rlen_d;
      rcnt_q    <= rcnt_d;
    end
  end

  assign ARREADY = (r_state_q == R_IDLE);
  assign RVALID  = (r_state_q == R_DATA);
  assign RLAST   = (r_state_q == R_DATA) && (rcnt_q == rlen_q);
  assign RID     = rid_q;
  assign RDATA   = '0;
  assign RRESP   = RESP_DECERR;

`ifdef DEFAULT_SLAVE_LOG_EN
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic [15:0]       err_cnt_q, err_cnt_d;
  logic [16:0]       cnt_sum;
  logic              unused_inputs;

  assign unused_inputs = ^AWLEN;

  // AR is written last so it wins a same-cycle tie
  always_comb begin
    err_addr_d = err_addr_q;
    if (aw_hs) err_addr_d = AWADDR;
    if (ar_hs) err_addr_d = ARADDR;
    cnt_sum   = {1'b0, err_cnt_q} + {15'b0, aw_hs} + {15'b0, ar_hs};
    err_cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      err_addr_q <= err_addr_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign err_addr = err_addr_q;
  assign err_cnt  = err_cnt_q;
`else
  logic unused_inputs;

  assign unused_inputs = ^{AWLEN, AWADDR, ARADDR, aw_hs, ar_hs};
`endif

endmodule

// File: tb/tb_axi_default_slave.sv
// Scoreboard bench for axi_default_slave; expected R/B responses are queued as
// stimulus is driven and compared at each handshake.
module tb_axi_default_slave;
  import axi_pkg::*;

  localparam int ID_W   = 8;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 4;

  logic              ACLK = 1'b0;
  logic              ARESETn;
  logic [ID_W-1:0]   AWID;
  logic [ADDR_W-1:0] AWADDR;
  logic [LEN_W-1:0]  AWLEN;
  logic              AWVALID;
  logic              AWREADY;
  logic              WLAST;
  logic              WVALID;
  logic              WREADY;
  logic [ID_W-1:0]   BID;
  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY;
  logic [ID_W-1:0]   ARID;
  logic [ADDR_W-1:0] ARADDR;
  logic [LEN_W-1:0]  ARLEN;
  logic              ARVALID;
  logic              ARREADY;
  logic [ID_W-1:0]   RID;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RLAST;
  logic              RVALID;
  logic              RREADY;
`ifdef DEFAULT_SLAVE_LOG_EN
  logic [ADDR_W-1:0] err_addr;
  logic [15:0]       err_cnt;
`endif

  axi_default_slave #(
    .ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
`ifdef DEFAULT_SLAVE_LOG_EN
    , .err_addr(err_addr), .err_cnt(err_cnt)
`endif
  );

  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic            last;
  } rexp_t;

  rexp_t           rq[$];
  logic [ID_W-1:0] bq[$];
  int n_chk = 0;
  int n_err = 0;
  int r_beats = 0;
  bit r_stall = 0;
  bit b_stall = 0;
  bit rr_toggle = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge ACLK);
      #1;
    end
  endtask

  function automatic logic rdy(input int which);
    case (which)
      0:       return AWREADY;
      1:       return WREADY;
      2:       return ARREADY;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_rdy(input int which, input string tag);
    int t = 0;
    while (!rdy(which) && t < 64) begin
      cyc();
      t++;
    end
    if (t >= 64) chk(tag, 0, 1);
  endtask

  task automatic write_txn(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr, input int beats);
    AWID = id; AWADDR = addr; AWLEN = LEN_W'(beats - 1); AWVALID = 1'b1;
    wait_rdy(0, "aw_timeout");
    cyc();
    AWVALID = 1'b0;
    bq.push_back(id);
    for (int i = 0; i < beats; i++) begin
      WVALID = 1'b1;
      WLAST  = (i == beats - 1);
      wait_rdy(1, "w_timeout");
      cyc();
    end
    WVALID = 1'b0;
    WLAST  = 1'b0;
  endtask

  task automatic read_issue(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr, input int len);
    rexp_t e;
    ARID = id; ARADDR = addr; ARLEN = LEN_W'(len); ARVALID = 1'b1;
    for (int i = 0; i <= len; i++) begin
      e.id = id;
      e.last = (i == len);
      rq.push_back(e);
    end
    wait_rdy(2, "ar_timeout");
    cyc();
    ARVALID = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((rq.size() != 0 || bq.size() != 0) && t < 500) begin
      cyc();
      t++;
    end
    if (t >= 500) chk("drain_timeout", 0, 1);
  endtask

  // Monitor: a handshake visible at the falling edge completes on the next rising edge
  always @(negedge ACLK) begin
    rexp_t           e;
    logic [ID_W-1:0] eb;
    if (!ARESETn) begin
      r_stall = 0;
      b_stall = 0;
    end else begin
      if (r_stall) chk("rvalid_hold", RVALID, 1);
      if (b_stall) chk("bvalid_hold", BVALID, 1);
      r_stall = RVALID && !RREADY;
      b_stall = BVALID && !BREADY;
      if (RVALID && RREADY) begin
        r_beats++;
        if (rq.size() == 0) chk("r_unexpected", 1, 0);
        else begin
          e = rq.pop_front();
          chk("rid", RID, e.id);
          chk("rlast", RLAST, e.last);
          chk("rdata", RDATA, 0);
          chk("rresp", RRESP, 2'b11);
        end
      end
      if (BVALID && BREADY) begin
        if (bq.size() == 0) chk("b_unexpected", 1, 0);
        else begin
          eb = bq.pop_front();
          chk("bid", BID, eb);
          chk("bresp", BRESP, 2'b11);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge ACLK);
      #2;
      if (rr_toggle) RREADY = ~RREADY;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int b0;
    ARESETn = 1'b0;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWVALID = 1'b0;
    WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARVALID = 1'b0; RREADY = 1'b0;
    cyc(3);
    ARESETn = 1'b1;

    chk("rst_awready", AWREADY, 1);
    chk("rst_arready", ARREADY, 1);
    chk("rst_wready", WREADY, 0);
    chk("rst_bvalid", BVALID, 0);
    chk("rst_rvalid", RVALID, 0);
    chk("rst_rlast", RLAST, 0);
    chk("rst_bid", BID, 0);
    chk("rst_rid", RID, 0);
    chk("rst_bresp", BRESP, 2'b11);
    chk("rst_rresp", RRESP, 2'b11);
`ifdef DEFAULT_SLAVE_LOG_EN
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_err_addr", err_addr, 0);
`endif

    // single write
    BREADY = 1'b1;
    AWID = 8'h12; AWVALID = 1'b1;
    cyc();
    AWVALID = 1'b0;
    chk("wr_wready", WREADY, 1);
    chk("wr_awready_low", AWREADY, 0);
    WVALID = 1'b1; WLAST = 1'b1;
    bq.push_back(8'h12);
    cyc();
    WVALID = 1'b0; WLAST = 1'b0;
    chk("wr_bvalid", BVALID, 1);
    chk("wr_bid", BID, 8'h12);
    drain();
    chk("wr_awready_back", AWREADY, 1);

    // 4-beat read
    RREADY = 1'b1;
    b0 = r_beats;
    read_issue(8'h21, 32'h0, 3);
    chk("rd_first_beat", RVALID, 1);
    n = 0;
    while (!ARREADY && n < 100) begin
      cyc();
      n++;
    end
    chk("rd_cycles", n, 4);
    chk("rd_beats", r_beats - b0, 4);
    chk("rd_q_empty", rq.size(), 0);

    // backpressure: toggling RREADY on a 16-beat read, BREADY low 5 cycles
    b0 = r_beats;
    rr_toggle = 1;
    read_issue(8'h33, 32'h0, 15);
    drain();
    rr_toggle = 0;
    RREADY = 1'b1;
    chk("bp_beats", r_beats - b0, 16);
    BREADY = 1'b0;
    write_txn(8'h44, 32'h0, 2);
    chk("bp_bvalid", BVALID, 1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("bp_b_held", BVALID, 1);
    end
    chk("bp_b_pending", bq.size(), 1);
    BREADY = 1'b1;
    drain();

    // AW and AR accepted in the same cycle
    AWID = 8'h55; AWVALID = 1'b1;
    ARID = 8'h66; ARLEN = 4'd1; ARVALID = 1'b1;
    rq.push_back('{id: 8'h66, last: 1'b0});
    rq.push_back('{id: 8'h66, last: 1'b1});
    bq.push_back(8'h55);
    cyc();
    AWVALID = 1'b0; ARVALID = 1'b0;
    chk("cc_wready", WREADY, 1);
    chk("cc_rvalid", RVALID, 1);
    for (int i = 0; i < 2; i++) begin
      WVALID = 1'b1;
      WLAST  = (i == 1);
      wait_rdy(1, "cc_w_timeout");
      cyc();
    end
    WVALID = 1'b0; WLAST = 1'b0;
    drain();

    // W before AW stalls
    WVALID = 1'b1; WLAST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("early_w_stall", WREADY, 0);
    end
    AWID = 8'h77; AWVALID = 1'b1;
    bq.push_back(8'h77);
    cyc();
    AWVALID = 1'b0;
    chk("early_w_ready", WREADY, 1);
    cyc();
    WVALID = 1'b0; WLAST = 1'b0;
    drain();

    // reset during beat 2 of a 4-beat read
    read_issue(8'h88, 32'h0, 3);
    cyc();
    chk("mid_rvalid", RVALID, 1);
    #2;
    ARESETn = 1'b0;
    #1;
    chk("rst_async_rvalid", RVALID, 0);
    chk("rst_async_rlast", RLAST, 0);
    rq.delete();
    cyc();
    ARESETn = 1'b1;
    chk("rel_arready", ARREADY, 1);
    chk("rel_awready", AWREADY, 1);
    chk("rel_rid", RID, 0);
    chk("rel_bvalid", BVALID, 0);
`ifdef DEFAULT_SLAVE_LOG_EN
    chk("rel_err_cnt", err_cnt, 0);
`endif
    write_txn(8'h9A, 32'h3000_0000, 1);
    b0 = r_beats;
    read_issue(8'hAB, 32'h4000_0004, 1);
    drain();
    chk("post_rst_beats", r_beats - b0, 2);
`ifdef DEFAULT_SLAVE_LOG_EN
    chk("log_err_cnt", err_cnt, 2);
    chk("log_err_addr", err_addr, 32'h4000_0004);
`endif

    // same-cycle AW/AR tie
    AWID = 8'hC1; AWADDR = 32'h5000_0000; AWVALID = 1'b1;
    ARID = 8'hC2; ARADDR = 32'h6000_0008; ARLEN = 4'd0; ARVALID = 1'b1;
    rq.push_back('{id: 8'hC2, last: 1'b1});
    bq.push_back(8'hC1);
    cyc();
    AWVALID = 1'b0; ARVALID = 1'b0;
`ifdef DEFAULT_SLAVE_LOG_EN
    chk("tie_err_cnt", err_cnt, 4);
    chk("tie_err_addr", err_addr, 32'h6000_0008);
`endif
    WVALID = 1'b1; WLAST = 1'b1;
    wait_rdy(1, "tie_w_timeout");
    cyc();
    WVALID = 1'b0; WLAST = 1'b0;
    drain();

    chk("end_rq_empty", rq.size(), 0);
    chk("end_bq_empty", bq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
